// File: rtl/spi_xfer_arbiter.sv
// spi_xfer_arbiter: shares one SPI master between NREQ requesters.
// Grants one requester at a time, drives the master's start pulse and
// operands, times the transfer with a fixed cycle budget and returns the
// captured read byte to the owner as a one-cycle response pulse.
// Build option: define SPI_ARB_FIXED_PRIO_EN for fixed priority (lowest
// index wins); otherwise round-robin arbitration is used.
module spi_xfer_arbiter #(
    parameter int NREQ      = 3,
    parameter int HDR       = 2,
    parameter int ADDR      = 7,
    parameter int DATA      = 8,
    parameter int START_CYC = 12,
    parameter int XFER_CYC  = 256
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid_i,
    output logic [NREQ-1:0]      req_ready_o,
    input  logic [NREQ*HDR-1:0]  req_hdr_i,
    input  logic [NREQ*ADDR-1:0] req_addr_i,
    input  logic [NREQ*DATA-1:0] req_wdata_i,
    input  logic [NREQ*2-1:0]    req_sel_i,
    output logic [NREQ-1:0]      rsp_valid_o,
    output logic [DATA-1:0]      rsp_data_o,
    output logic                 busy_o,
    output logic                 m_start_o,
    output logic [1:0]           m_slaveselect_o,
    output logic [HDR-1:0]       m_header_o,
    output logic [ADDR-1:0]      m_addr_o,
    output logic [DATA-1:0]      m_wdata_o,
    input  logic [DATA-1:0]      m_rdata_i
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t           state_q;
    logic [15:0]      cnt_q;
    logic [IW-1:0]    owner_q;
    logic [NREQ-1:0]  rsp_valid_q;
    logic [DATA-1:0]  rsp_data_q;
    logic             m_start_q;
    logic [1:0]       m_sel_q;
    logic [HDR-1:0]   m_hdr_q;
    logic [ADDR-1:0]  m_addr_q;
    logic [DATA-1:0]  m_wdata_q;

    logic             grant_found;
    logic [IW-1:0]    grant_idx;

    // Per-requester views of the packed operand buses
    logic [HDR-1:0]   hdr_a   [NREQ];
    logic [ADDR-1:0]  addr_a  [NREQ];
    logic [DATA-1:0]  wdata_a [NREQ];
    logic [1:0]       sel_a   [NREQ];

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign hdr_a[gi]   = req_hdr_i[gi*HDR +: HDR];
            assign addr_a[gi]  = req_addr_i[gi*ADDR +: ADDR];
            assign wdata_a[gi] = req_wdata_i[gi*DATA +: DATA];
            assign sel_a[gi]   = req_sel_i[gi*2 +: 2];
        end
    endgenerate

`ifdef SPI_ARB_FIXED_PRIO_EN
    // Fixed priority: scan from the top so the lowest pending index wins last
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_valid_i[IW'(k)]) begin
                grant_found = 1'b1;
                grant_idx   = IW'(k);
            end
        end
    end
`else
    logic [IW-1:0] last_owner_q;
    int            cand;
    logic [IW-1:0] cand_idx;

    // Round-robin: first pending requester after the previous owner wins
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        cand_idx    = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand     = (int'(last_owner_q) + 1 + k) % NREQ;
            cand_idx = IW'(cand);
            if (!grant_found && req_valid_i[cand_idx]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx;
            end
        end
    end

    // Remember the owner of the most recent accept for the next search
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_owner_q <= IW'(NREQ - 1);
        end else if (state_q == ST_IDLE && grant_found) begin
            last_owner_q <= grant_idx;
        end
    end
`endif

    // Accept is offered combinationally in IDLE only, and never while in reset
    always_comb begin
        req_ready_o = '0;
        if (!reset && state_q == ST_IDLE && grant_found) begin
            req_ready_o[grant_idx] = 1'b1;
        end
    end

    // Transaction FSM: accept, hold start, wait out the transfer, respond
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            owner_q     <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            m_start_q   <= 1'b0;
            m_sel_q     <= '0;
            m_hdr_q     <= '0;
            m_addr_q    <= '0;
            m_wdata_q   <= '0;
        end else begin
            rsp_valid_q <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (grant_found) begin
                        m_hdr_q   <= hdr_a[grant_idx];
                        m_addr_q  <= addr_a[grant_idx];
                        m_wdata_q <= wdata_a[grant_idx];
                        m_sel_q   <= sel_a[grant_idx];
                        owner_q   <= grant_idx;
                        cnt_q     <= 16'(START_CYC - 1);
                        m_start_q <= 1'b1;
                        state_q   <= ST_START;
                    end
                end
                ST_START: begin
                    if (cnt_q == 16'd0) begin
                        cnt_q     <= 16'(XFER_CYC - 1);
                        m_start_q <= 1'b0;
                        state_q   <= ST_WAIT;
                    end else begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                end
                ST_WAIT: begin
                    if (cnt_q == 16'd0) begin
                        rsp_data_q           <= m_rdata_i;
                        rsp_valid_q[owner_q] <= 1'b1;
                        state_q              <= ST_RESP;
                    end else begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                end
                ST_RESP: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy_o          = (state_q != ST_IDLE);
    assign rsp_valid_o     = rsp_valid_q;
    assign rsp_data_o      = rsp_data_q;
    assign m_start_o       = m_start_q;
    assign m_slaveselect_o = m_sel_q;
    assign m_header_o      = m_hdr_q;
    assign m_addr_o        = m_addr_q;
    assign m_wdata_o       = m_wdata_q;

endmodule

// File: tb/tb_spi_xfer_arbiter.sv
// Scoreboard bench for spi_xfer_arbiter: stimulus queues expected grants and
// responses, a negedge monitor pops and compares them as the DUT presents them.
module tb_spi_xfer_arbiter;

    localparam int NREQ = 3;
    localparam int HDR  = 2;
    localparam int ADDR = 7;
    localparam int DATA = 8;
    localparam int GAP  = 270;  // START_CYC + XFER_CYC + 2
    localparam int LAT  = 269;  // accept cycle to rsp_valid cycle

    logic                 clk = 1'b0;
    logic                 reset;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*HDR-1:0]  req_hdr;
    logic [NREQ*ADDR-1:0] req_addr;
    logic [NREQ*DATA-1:0] req_wdata;
    logic [NREQ*2-1:0]    req_sel;
    logic [NREQ-1:0]      rsp_valid;
    logic [DATA-1:0]      rsp_data;
    logic                 busy;
    logic                 m_start;
    logic [1:0]           m_slaveselect;
    logic [HDR-1:0]       m_header;
    logic [ADDR-1:0]      m_addr;
    logic [DATA-1:0]      m_wdata;
    logic [DATA-1:0]      m_rdata;

    always #5 clk = ~clk;

    spi_xfer_arbiter dut (
        .clk             (clk),
        .reset           (reset),
        .req_valid_i     (req_valid),
        .req_ready_o     (req_ready),
        .req_hdr_i       (req_hdr),
        .req_addr_i      (req_addr),
        .req_wdata_i     (req_wdata),
        .req_sel_i       (req_sel),
        .rsp_valid_o     (rsp_valid),
        .rsp_data_o      (rsp_data),
        .busy_o          (busy),
        .m_start_o       (m_start),
        .m_slaveselect_o (m_slaveselect),
        .m_header_o      (m_header),
        .m_addr_o        (m_addr),
        .m_wdata_o       (m_wdata),
        .m_rdata_i       (m_rdata)
    );

    // Slave model: read byte = {addr,0} ^ 8'h76
    assign m_rdata = {m_addr, 1'b0} ^ 8'h76;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc++;

    typedef struct {
        int idx;
        int gap;
    } grant_t;

    typedef struct {
        int         owner;
        logic [7:0] data;
        logic [1:0] hdr;
        logic [6:0] addr;
        logic [7:0] wdata;
        logic [1:0] sel;
    } rsp_t;

    grant_t gq[$];
    rsp_t   rq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Hand-computed operands and read bytes per requester
    function automatic rsp_t exp_rsp(input int i);
        rsp_t r;
        case (i)
            0:       r = '{0, 8'h56, 2'b01, 7'h10, 8'h11, 2'b00};
            1:       r = '{1, 8'h3C, 2'b10, 7'h25, 8'hA5, 2'b01};
            default: r = '{2, 8'h88, 2'b11, 7'h7F, 8'hC3, 2'b10};
        endcase
        return r;
    endfunction

    // Monitor state
    bit     pending = 0;
    int     acc_cyc = 0;
    int     start_cnt = 0;
    int     start_first = 0;
    grant_t g;
    rsp_t   r;

    always @(negedge clk) begin
        if (reset) begin
            pending = 0;
        end else begin
            if (pending && m_start) begin
                start_cnt++;
                if (start_cnt == 1) start_first = cyc;
            end
            if (|req_ready) begin
                if (gq.size() == 0) begin
                    chk("unexpected_grant", 32'(req_ready), 32'd0);
                end else begin
                    g = gq.pop_front();
                    chk("grant", 32'(req_ready), 32'(1) << g.idx);
                    $display("grant to %0d at cycle %0d", g.idx, cyc);
                    if (g.gap != 0) chk("accept_gap", 32'(cyc - acc_cyc), 32'(g.gap));
                end
                acc_cyc     = cyc;
                pending     = 1;
                start_cnt   = 0;
                start_first = 0;
            end
            if (|rsp_valid) begin
                if (rq.size() == 0) begin
                    chk("unexpected_rsp", 32'(rsp_valid), 32'd0);
                end else begin
                    r = rq.pop_front();
                    $display("response to %0d data %02h at cycle %0d", r.owner, rsp_data, cyc);
                    chk("rsp_owner", 32'(rsp_valid), 32'(1) << r.owner);
                    chk("rsp_data", 32'(rsp_data), 32'(r.data));
                    chk("rsp_latency", 32'(cyc - acc_cyc), 32'(LAT));
                    chk("start_len", 32'(start_cnt), 32'd12);
                    chk("start_first", 32'(start_first - acc_cyc), 32'd1);
                    chk("m_header", 32'(m_header), 32'(r.hdr));
                    chk("m_addr", 32'(m_addr), 32'(r.addr));
                    chk("m_wdata", 32'(m_wdata), 32'(r.wdata));
                    chk("m_sel", 32'(m_slaveselect), 32'(r.sel));
                end
                pending = 0;
            end
        end
    end

    // Wait (bounded) for req_ready[i]; optionally drop req_valid[i] after the accept edge
    task automatic wait_grant(input int i, input bit drop);
        bit got;
        got = 0;
        for (int n = 0; n < 1000 && !got; n++) begin
            @(negedge clk);
            if (req_ready[i]) got = 1;
        end
        if (!got) chk("grant_timeout", 32'd0, 32'(i + 1));
        @(posedge clk);
        #1;
        if (drop) req_valid[i] = 1'b0;
    endtask

    task automatic wait_idle();
        bit done;
        done = 0;
        for (int n = 0; n < 2000 && !done; n++) begin
            @(negedge clk);
            if (!busy) done = 1;
        end
        if (!done) chk("idle_timeout", 32'(busy), 32'd0);
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = '0;
        req_hdr   = {2'b11, 2'b10, 2'b01};
        req_addr  = {7'h7F, 7'h25, 7'h10};
        req_wdata = {8'hC3, 8'hA5, 8'h11};
        req_sel   = {2'b10, 2'b01, 2'b00};

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_data", 32'(rsp_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_m_start", 32'(m_start), 32'd0);
        chk("rst_m_sel", 32'(m_slaveselect), 32'd0);
        chk("rst_m_header", 32'(m_header), 32'd0);
        chk("rst_m_addr", 32'(m_addr), 32'd0);
        chk("rst_m_wdata", 32'(m_wdata), 32'd0);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Single request from requester 1
        gq.push_back(grant_t'{1, 0});
        rq.push_back(exp_rsp(1));
        req_valid[1] = 1'b1;
        wait_grant(1, 1);
        wait_idle();
        repeat (5) @(posedge clk);
        #1;
        chk("rsp_data_hold", 32'(rsp_data), 32'h3C);

        // Late arrival of req 2 during WAIT of req 0, plus a withdrawn req 1 pulse
        gq.push_back(grant_t'{0, 0});
        gq.push_back(grant_t'{2, GAP});
        rq.push_back(exp_rsp(0));
        rq.push_back(exp_rsp(2));
        req_valid[0] = 1'b1;
        wait_grant(0, 1);
        repeat (50) @(posedge clk);
        #1;
        req_valid[2] = 1'b1;
        @(posedge clk);
        #1;
        req_valid[1] = 1'b1;
        @(posedge clk);
        #1;
        req_valid[1] = 1'b0;
        wait_grant(2, 1);
        wait_idle();
        repeat (3) @(posedge clk);
        #1;

        // Reset in the middle of WAIT: no response afterwards
        gq.push_back(grant_t'{1, 0});
        req_valid[1] = 1'b1;
        wait_grant(1, 1);
        repeat (99) @(posedge clk);
        #2;
        chk("busy_before_reset", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        chk("mid_rst_m_start", 32'(m_start), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_rsp_data", 32'(rsp_data), 32'd0);
        chk("mid_rst_m_addr", 32'(m_addr), 32'd0);
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
        repeat (300) @(posedge clk);
        #1;
        chk("post_rst_busy", 32'(busy), 32'd0);

        // All requesters hold req_valid continuously
        req_valid = '1;
`ifdef SPI_ARB_FIXED_PRIO_EN
        gq.push_back(grant_t'{0, 0});
        gq.push_back(grant_t'{0, GAP});
        gq.push_back(grant_t'{0, GAP});
        gq.push_back(grant_t'{0, GAP});
        gq.push_back(grant_t'{1, GAP});
        for (int k = 0; k < 4; k++) rq.push_back(exp_rsp(0));
        rq.push_back(exp_rsp(1));
        for (int k = 0; k < 4; k++) wait_grant(0, 0);
        req_valid[0] = 1'b0;
        wait_grant(1, 0);
`else
        gq.push_back(grant_t'{0, 0});
        gq.push_back(grant_t'{1, GAP});
        gq.push_back(grant_t'{2, GAP});
        gq.push_back(grant_t'{0, GAP});
        rq.push_back(exp_rsp(0));
        rq.push_back(exp_rsp(1));
        rq.push_back(exp_rsp(2));
        rq.push_back(exp_rsp(0));
        wait_grant(0, 0);
        wait_grant(1, 0);
        wait_grant(2, 0);
        wait_grant(0, 0);
`endif
        req_valid = '0;
        wait_idle();
        repeat (5) @(posedge clk);
        #1;
        chk("grant_queue_empty", 32'(gq.size()), 32'd0);
        chk("rsp_queue_empty", 32'(rq.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_xfer_arbiter.md
# spi_xfer_arbiter

Shares one SPI master between `NREQ` requesters. Each requester presents a complete SPI transaction: header, address, write data and slave select. The block grants one requester at a time and drives the master's start pulse and operand bus. It times the transfer with a fixed cycle budget, since the master has no done flag, then returns the captured read byte to the owner. It sits between the register-access clients and the SPI master, in the `clk` domain.

## Interface
Parameters:
- `NREQ`, 3: number of requesters (2..8).
- `HDR`, 2: header width.
- `ADDR`, 7: address width.
- `DATA`, 8: payload width.
- `START_CYC`, 12: clk cycles `m_start` is held high. Must be ≥ one SCLK period of the master.
- `XFER_CYC`, 256: clk cycles from `m_start` fall until read data is valid, including CS deassert guard.

Ports (packed vectors, requester i at slice i):
- `clk`  in  1: clock.
- `reset`  in  1: asynchronous, active-high reset.
- `req_valid`  in  NREQ: request pending, one bit per requester.
- `req_ready`  out  NREQ: one-hot accept.
- `req_hdr`  in  NREQ*HDR: per-requester header.
- `req_addr`  in  NREQ*ADDR: per-requester address.
- `req_wdata`  in  NREQ*DATA: per-requester write data.
- `req_sel`  in  NREQ*2: per-requester slave select code.
- `rsp_valid`  out  NREQ: one-cycle completion pulse to the owner.
- `rsp_data`  out  DATA: read byte. Valid with `rsp_valid`; held until the next response.
- `busy`  out  1: transaction in flight (state ≠ IDLE).
- `m_start`  out  1: start to the SPI master.
- `m_slaveselect`  out  2: to the master.
- `m_header`  out  HDR: to the master.
- `m_addr`  out  ADDR: to the master.
- `m_wdata`  out  DATA: to the master.
- `m_rdata`  in  DATA: read data from the master.

## Operation
- FSM states: IDLE → START → WAIT → RESP → IDLE.
- **IDLE:**
  - If any `req_valid` bit is set, arbitration picks winner w.
  - `req_ready[w]`=1 combinationally in this cycle only. The request is accepted at this edge.
  - The block latches w's hdr/addr/wdata/sel into the `m_*` registers, records the owner, and goes to START.
  - `req_ready` is 0 in every other state.
- **START:**
  - `m_start`=1 for exactly `START_CYC` cycles. A 16-bit down-counter is loaded at accept.
  - On expiry the block reloads the counter with `XFER_CYC` and goes to WAIT.
- **WAIT:**
  - `m_start`=0 and `m_*` operands are held stable.
  - At counter zero the block latches `m_rdata` into `rsp_data` and goes to RESP.
- **RESP:** `rsp_valid[owner]`=1 for one cycle, then IDLE.
- **Arbitration (default):** round-robin.
  - Search starts at `last_owner+1` modulo NREQ.
  - `last_owner` updates at accept.
  - Reset value of `last_owner` is NREQ-1, so requester 0 wins first.
- **Requester rules:**
  - A requester holds `req_valid` and its operands stable until accepted.
  - Deasserting before accept drops the request without side effects.
  - The same requester may re-request in the RESP cycle. It is considered in the following IDLE cycle.
- **Simultaneous events:**
  - New `req_valid` during START/WAIT/RESP is ignored until IDLE.
  - Requests remain pending and are not lost.
- **Reset mid-transfer (async):**
  - All outputs return to reset values immediately, including `m_start`=0.
  - The pending response is discarded. No `rsp_valid` is issued.
- **Reset values:**
  - `req_ready`=0, `rsp_valid`=0, `rsp_data`=0, `busy`=0.
  - `m_start`=0, `m_slaveselect`=0, `m_header`=0, `m_addr`=0, `m_wdata`=0.
  - state=IDLE, counter=0.

## Timing
- Accept edge = cycle 0.
- `m_start` is high on cycles 1..`START_CYC`.
- The `m_*` operands are valid from cycle 1 until the next accept.
- `rsp_data` is latched at the end of cycle `START_CYC`+`XFER_CYC`.
- `rsp_valid` is high on cycle `START_CYC`+`XFER_CYC`+1.
- The earliest next accept is cycle `START_CYC`+`XFER_CYC`+2.
- Back-to-back throughput is one transaction per `START_CYC`+`XFER_CYC`+2 cycles.
- Worst-case wait for a continuously requesting client is NREQ-1 full transactions.

## Configuration
- Macro: `SPI_ARB_FIXED_PRIO_EN`.
- **Defined:** fixed priority. The lowest index with `req_valid` always wins. `last_owner` is not used.
- **Undefined:** round-robin as described under Operation.
- The FSM, timing and ports are identical in both builds.

## Test plan
- **Single request, default parameters:** req 1 asserts hdr=2'b10, addr=7'h25, wdata=8'hA5, sel=2'b01.
  - `req_ready[1]` pulses at cycle 0.
  - `m_start` is high on cycles 1–12.
  - The slave model returns 8'h3C; `rsp_valid[1]` fires at cycle 269 with `rsp_data`=8'h3C.
- **Round-robin fairness:** all three requesters hold `req_valid` continuously.
  - Grants go 0,1,2,0.
  - Accepts are spaced exactly 270 cycles apart.
- **Fixed priority (`SPI_ARB_FIXED_PRIO_EN`):** same stimulus as the fairness test.
  - Requester 0 is granted repeatedly.
  - Requester 1 is granted only after req 0 drops.
- **Late arrival:** req 2 asserts during WAIT of req 0.
  - No `req_ready[2]` until after `rsp_valid[0]`.
  - Req 2 is accepted in the first IDLE cycle.
- **Reset mid-WAIT:** assert reset at cycle 100 after accept.
  - `m_start`, `busy`, `rsp_valid` and `rsp_data` go to 0 immediately.
  - No response is issued after reset release.
  - The next grant goes to requester 0.
- **Request withdrawn:** req 1 pulses `req_valid` for one cycle while busy.
  - No grant to req 1.
  - No `rsp_valid[1]`.
